// File: rtl/morse_pkg.sv
// Shared definitions for the Morse transmitter character path.
// Lookup FSM state encoding and the ASCII constants used by case folding.
// No logic here; imported by the lookup block and its normaliser.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] LOWER_A  = 7'h61;
    localparam logic [6:0] LOWER_Z  = 7'h7A;
    localparam int         CASE_BIT = 5;

endpackage

// File: rtl/normalizador_caracter.sv
// Case-fold normaliser: maps 'a'..'z' onto 'A'..'Z' when fold is set.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake; output follows the inputs.
module normalizador_caracter
    import morse_pkg::*;
#(
    parameter int WIDTH   = 7,
    parameter bit FOLD_EN = 1'b1
) (
    input  logic [WIDTH-1:0] char,
    input  logic             fold,
    output logic [WIDTH-1:0] char_n
);

    if (FOLD_EN) begin : g_fold
        logic in_range;

        // Only the lowercase ASCII letters are folded; compare on the full width
        // so wider characters outside the 7-bit range pass through untouched.
        assign in_range = (char >= WIDTH'(LOWER_A)) && (char <= WIDTH'(LOWER_Z));

        // Clearing the case bit turns a lowercase letter into its uppercase twin.
        always_comb begin
            char_n = char;
            if (fold && in_range) begin
                char_n[CASE_BIT] = 1'b0;
            end
        end
    end else begin : g_nofold
        logic unused_fold;

        assign unused_fold = fold;
        assign char_n      = char;
    end

endmodule

// File: rtl/buscador_caracter.sv
// Sequential character lookup over a writable DEPTH-entry table, lowest matching index wins.
// Latency: hit at index k after k+1 cycles, miss after DEPTH cycles; result then held in DONE.
// Backpressure: in_ready/tbl_ready only in IDLE; result held stable until out_valid && out_ready.
module buscador_caracter
    import morse_pkg::*;
#(
    parameter  int WIDTH   = 7,
    parameter  int DEPTH   = 64,
    parameter  bit FOLD_EN = 1'b1,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_char,
    input  logic             fold_case,
    input  logic             tbl_we,
    input  logic [IDX_W-1:0] tbl_addr,
    input  logic [WIDTH-1:0] tbl_data,
    output logic             tbl_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] char_q,  char_d;
    logic             fold_q,  fold_d;
    logic [IDX_W-1:0] cnt_q,   cnt_d;
    logic             hit_q,   hit_d;
    logic [IDX_W-1:0] idx_q,   idx_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;

    logic [WIDTH-1:0] in_char_n;
    logic [WIDTH-1:0] ent_n;
    logic             addr_ok;
    logic             tbl_wr;
    logic             match;

    // Status outputs decode the registered state; reset also drops the ready flags.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign tbl_ready = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_hit   = hit_q;
    assign out_idx   = idx_q;

    // Incoming character is normalised once, at acceptance, with its own fold flag.
    normalizador_caracter #(
        .WIDTH   (WIDTH),
        .FOLD_EN (FOLD_EN)
    ) u_norm_in (
        .char   (in_char),
        .fold   (fold_case),
        .char_n (in_char_n)
    );

    // Table entry under the scan pointer, normalised with the latched fold flag.
    normalizador_caracter #(
        .WIDTH   (WIDTH),
        .FOLD_EN (FOLD_EN)
    ) u_norm_tbl (
        .char   (mem_q[cnt_q]),
        .fold   (fold_q),
        .char_n (ent_n)
    );

    // Addresses past the last entry (non power-of-two DEPTH) are ignored.
    assign addr_ok = ({1'b0, tbl_addr} < (IDX_W + 1)'(DEPTH));
    assign tbl_wr  = tbl_we && tbl_ready && addr_ok;
    assign match   = vld_q[cnt_q] && (ent_n == char_q);

    // Table write port: data and valid bit updated together, only while idle.
    always_comb begin
        mem_d = mem_q;
        vld_d = vld_q;
        if (tbl_wr) begin
            mem_d[tbl_addr] = tbl_data;
            vld_d[tbl_addr] = 1'b1;
        end
    end

    // Lookup FSM: accept, scan one entry per cycle, then hold the result for the consumer.
    always_comb begin
        state_d = state_q;
        char_d  = char_q;
        fold_d  = fold_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    char_d  = in_char_n;
                    fold_d  = fold_case;
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (match) begin
                    hit_d   = 1'b1;
                    idx_d   = cnt_q;
                    state_d = DONE;
                end else if (cnt_q == LAST_IDX) begin
                    hit_d   = 1'b0;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Entry data carries no reset; only the valid bits decide whether an entry can match.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control and result registers; reset aborts any lookup in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vld_q   <= '0;
            char_q  <= '0;
            fold_q  <= 1'b0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            char_q  <= char_d;
            fold_q  <= fold_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
        end
    end

    // A stalled result must not move while the consumer is not ready.
    a_done_stable: assert property (@(posedge clk) disable iff (rst)
        (state_q == DONE && !out_ready) |=> (state_q == DONE && $stable(hit_q) && $stable(idx_q)));

endmodule

// File: tb/tb_buscador_caracter.sv
module tb_buscador_caracter;

    localparam int WIDTH = 7;
    localparam int DEPTH = 64;
    localparam int IDX_W = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_char = '0;
    logic             fold_case = 1'b0;
    logic             tbl_we = 1'b0;
    logic [IDX_W-1:0] tbl_addr = '0;
    logic [WIDTH-1:0] tbl_data = '0;
    logic             tbl_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_hit;
    logic [IDX_W-1:0] out_idx;
    logic             busy;

    int n_chk = 0;
    int n_err = 0;

    // Reference table: what software believes has been written and is valid.
    int ref_mem [DEPTH];
    bit ref_vld [DEPTH];

    always #5 clk = ~clk;

    buscador_caracter #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .FOLD_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .fold_case (fold_case),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
        .tbl_ready (tbl_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hit   (out_hit),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int norm(input int c, input bit f);
        if (f && c >= 'h61 && c <= 'h7A) return c - 32;
        return c;
    endfunction

    // Lowest valid entry whose folded value equals the folded character, or -1.
    function automatic int ref_find(input int c, input bit f);
        for (int k = 0; k < DEPTH; k++) begin
            if (ref_vld[k] && norm(ref_mem[k], f) == norm(c, f)) return k;
        end
        return -1;
    endfunction

    task automatic wr(input int a, input int d);
        @(negedge clk);
        tbl_we   = 1'b1;
        tbl_addr = IDX_W'(a);
        tbl_data = WIDTH'(d);
        @(negedge clk);
        tbl_we    = 1'b0;
        ref_mem[a] = d;
        ref_vld[a] = 1'b1;
    endtask

    // One lookup; wa>=0 adds a table write in the acceptance cycle, poke hammers
    // a write to entry 5 throughout SCAN/DONE, hold stalls the consumer.
    task automatic lookup(input string tag, input int c, input bit f, input int hold,
                          input bit poke, input int wa, input int wd,
                          output bit g_hit, output int g_idx, output int g_lat);
        int  ek;
        bit  eh;
        int  ei;
        int  el;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_char   = WIDTH'(c);
        fold_case = f;
        if (wa >= 0) begin
            tbl_we   = 1'b1;
            tbl_addr = IDX_W'(wa);
            tbl_data = WIDTH'(wd);
            ref_mem[wa] = wd;
            ref_vld[wa] = 1'b1;
        end
        ek = ref_find(c, f);
        eh = (ek >= 0);
        ei = eh ? ek : 0;
        el = eh ? ek + 1 : DEPTH;
        @(negedge clk);
        in_valid = 1'b0;
        tbl_we   = 1'b0;
        g_lat    = 0;
        while (!out_valid && g_lat < DEPTH + 4) begin
            if (poke) begin
                tbl_we   = 1'b1;
                tbl_addr = IDX_W'(5);
                tbl_data = '0;
            end
            @(negedge clk);
            g_lat++;
        end
        g_hit = out_hit;
        g_idx = int'(out_idx);
        chk({tag, "_hit"}, 32'(out_hit), 32'(eh));
        chk({tag, "_idx"}, 32'(out_idx), 32'(ei));
        chk({tag, "_lat"}, g_lat, el);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_hit"}, 32'(out_hit), 32'(eh));
            chk({tag, "_hold_idx"}, 32'(out_idx), 32'(ei));
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        tbl_we    = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_released"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit g_hit;
        int g_idx;
        int g_lat;
        bit seen;

        for (int k = 0; k < DEPTH; k++) begin
            ref_mem[k] = 0;
            ref_vld[k] = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_tbl_ready", 32'(tbl_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_hit", 32'(out_hit), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_tbl_ready", 32'(tbl_ready), 32'd1);

        // Directed lookups
        wr(0, 'h41);
        wr(5, 'h53);
        lookup("hit_S", 'h53, 1'b0, 0, 1'b0, -1, 0, g_hit, g_idx, g_lat);
        chk("hit_S_const", g_idx, 5);
        chk("hit_S_lat_const", g_lat, 6);
        lookup("miss_Q", 'h51, 1'b0, 0, 1'b0, -1, 0, g_hit, g_idx, g_lat);
        chk("miss_Q_lat_const", g_lat, 64);
        wr(3, 'h45);
        wr(9, 'h45);
        lookup("prio_E", 'h45, 1'b0, 0, 1'b0, -1, 0, g_hit, g_idx, g_lat);
        chk("prio_E_const", g_idx, 3);
        lookup("fold_s", 'h73, 1'b1, 0, 1'b0, -1, 0, g_hit, g_idx, g_lat);
        chk("fold_s_const", g_idx, 5);
        lookup("nofold_s", 'h73, 1'b0, 0, 1'b0, -1, 0, g_hit, g_idx, g_lat);
        chk("nofold_s_const", 32'(g_hit), 32'd0);
        lookup("first_A", 'h41, 1'b0, 0, 1'b0, -1, 0, g_hit, g_idx, g_lat);
        chk("first_A_lat_const", g_lat, 1);
        wr(63, 'h7E);
        lookup("last_tilde", 'h7E, 1'b0, 0, 1'b0, -1, 0, g_hit, g_idx, g_lat);
        chk("last_const", g_idx, 63);
        lookup("same_cycle_wr", 'h5A, 1'b0, 0, 1'b0, 2, 'h5A, g_hit, g_idx, g_lat);
        chk("same_cycle_wr_const", g_idx, 2);

        // Stall in DONE while hammering a write that must be dropped
        lookup("stall", 'h53, 1'b0, 10, 1'b1, -1, 0, g_hit, g_idx, g_lat);
        lookup("after_drop", 'h53, 1'b0, 0, 1'b0, -1, 0, g_hit, g_idx, g_lat);
        chk("after_drop_const", g_idx, 5);

        // Reset in the middle of a scan
        @(negedge clk);
        in_valid = 1'b1;
        in_char  = WIDTH'('h51);
        fold_case = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_hit", 32'(out_hit), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < DEPTH; k++) ref_vld[k] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_result", 32'(seen), 32'd0);
        lookup("post_rst_A", 'h41, 1'b0, 0, 1'b0, -1, 0, g_hit, g_idx, g_lat);
        chk("post_rst_A_const", 32'(g_hit), 32'd0);

        // Randomized traffic against the reference table
        for (int it = 0; it < 40; it++) begin
            int c;
            int n_wr;
            int wa;
            int wd;
            n_wr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
            for (int j = 0; j < n_wr; j++) begin
                wd = ($urandom_range(0, 3) == 0) ? int'($urandom_range('h61, 'h7A))
                                                  : int'($urandom_range('h41, 'h5A));
                wr(int'($urandom_range(0, DEPTH - 1)), wd);
            end
            case ($urandom_range(0, 5))
                0:       c = int'($urandom_range('h61, 'h7A));
                1:       begin
                             wd = int'($urandom_range(0, 3));
                             c = (wd == 0) ? 'h40 : (wd == 1) ? 'h5B : (wd == 2) ? 'h60 : 'h7B;
                         end
                default: c = int'($urandom_range('h41, 'h5A));
            endcase
            wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : -1;
            wd = int'($urandom_range('h41, 'h5A));
            lookup("rnd", c, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0,
                   wa, wd, g_hit, g_idx, g_lat);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
